logic_issue_ctrl: RTL and testbench
===================================

# logic_issue_ctrl

Sequential front end for the 8-bit ALU logic path. It accepts logic-operation commands over a valid/ready handshake and buffers them in a 2-entry FIFO. It issues each command to an instantiated `logic_unit` through registered operands, then captures `Logic_Out` into a held result with a zero flag and a sequence tag. It sits directly upstream of `logic_unit` and adapts it to streaming producers and consumers.

## Interface
Parameters:
- `TAG_W`, 4: width of the sequence tag attached to each command.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `cmd_valid`  in  1  producer presents a command.
- `cmd_ready`  out  1  block can accept a command; equals `!rst && !fifo_full`.
- `cmd_A`  in  8  operand A.
- `cmd_B`  in  8  operand B.
- `cmd_Sel`  in  2  logic select.
- `res_valid`  out  1  result held and valid.
- `res_ready`  in  1  consumer takes the result.
- `res_data`  out  8  captured `Logic_Out`.
- `res_zero`  out  1  1 when `res_data == 8'h00`.
- `res_tag`  out  TAG_W  tag of the command that produced `res_data`.

## Operation
- Accept: a command is taken on an edge where `cmd_valid && cmd_ready`. It is pushed into the FIFO as {tag, A, B, Sel}, using the current tag counter value. The tag counter then increments, wrapping from 2^TAG_W-1 to 0.
- FIFO: 2 entries, no bypass. When the FIFO is full, `cmd_ready` is 0, even if a pop happens in the same cycle.
- Logic_Sel encoding, from the shared package: 00 AND, 01 OR, 10 XOR, 11 NOT A (B ignored).
- FSM states:
  - IDLE: if the FIFO is non-empty, pop the head into the operand registers (`op_A`, `op_B`, `op_Sel`, `op_tag`) and go to EXEC. Otherwise stay in IDLE.
  - EXEC: `logic_unit` is driven from the operand registers. On this edge, capture `Logic_Out` into `res_data`, compute `res_zero`, copy `op_tag` to `res_tag`, set `res_valid` to 1, and go to HOLD.
  - HOLD: result outputs are stable while `res_valid && !res_ready`.
    - If `res_ready` is 1 and the FIFO is non-empty: pop into the operand registers, clear `res_valid`, go to EXEC.
    - If `res_ready` is 1 and the FIFO is empty: clear `res_valid`, go to IDLE.
- Operands, results and tag are held until overwritten; there is no zeroing on consume.

## Timing
- Reset values:
  - `cmd_ready` 0 while `rst` is high, 1 on the first cycle after.
  - `res_valid`, `res_zero` 0; `res_data` 8'h00; `res_tag` 0.
  - FSM in IDLE; FIFO empty; tag counter 0; operand registers 0.
- Latency: for a command accepted at edge N into an empty FIFO with the FSM in IDLE, the pop happens at N+1 and `res_valid` rises after edge N+2.
- Throughput: one result per 2 cycles while the consumer holds `res_ready` = 1.
- A push and a pop in the same cycle leave the FIFO occupancy unchanged.
- Back-pressure: with `res_ready` = 0, a third command fills the FIFO and `cmd_ready` drops. `cmd_ready` rises on the cycle after the first HOLD→EXEC pop.
- Reset mid-operation: on the next edge the FIFO is flushed, in-flight results are dropped and the tag restarts at 0. No partial result is emitted.
- `res_zero` is registered together with `res_data`; it is never combinational from `Logic_Out`.

## Structure
- Package `alu_pkg`:
  - `LOGIC_AND`, `LOGIC_OR`, `LOGIC_XOR`, `LOGIC_NOTA` select constants.
  - FSM state enum {IDLE, EXEC, HOLD}.
  - Command struct {tag, A, B, Sel}.
- Sub-module `cmd_fifo2`: 2-entry synchronous FIFO with push, pop, full and empty, and synchronous reset.
- `logic_unit` is instantiated unmodified, driven from the operand registers.

## Test plan
- Reset release: after `rst` drops, `cmd_ready` = 1, `res_valid` = 0, `res_data` = 00. Asserting `rst` in HOLD clears `res_valid` on the next edge.
- A=0A, B=02, issued back-to-back with Sel 0, 1, 2, 3 and `res_ready` = 1 → results in order:
  - 02 / tag 0
  - 0A / tag 1
  - 08 / tag 2
  - F5 / tag 3
  - `res_zero` = 0 throughout.
- A=F6, B=09, Sel=AND → `res_data` = 00, `res_zero` = 1. The first result appears 2 cycles after accept.
- Stall: `res_ready` = 0 while 3 commands are sent → first result held stable, `cmd_ready` = 0 after the 3rd accept. Release → all 3 results drain in order and `cmd_ready` rises again.
- Tag wrap: 17 commands → tags 0..15, then 0.
- Random `cmd_valid` / `res_ready` toggling against a scoreboard model → no lost, duplicated or reordered results.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared definitions for the 8-bit ALU logic path.
//   - Logic_Sel encodings used by logic_unit and its front end.
//   - FSM state type for the issue controller.
//   - Operand payload of a logic command. The sequence tag is prepended in
//     logic_issue_ctrl because its width is a parameter of that module.
package alu_pkg;

  localparam logic [1:0] LOGIC_AND  = 2'b00;
  localparam logic [1:0] LOGIC_OR   = 2'b01;
  localparam logic [1:0] LOGIC_XOR  = 2'b10;
  localparam logic [1:0] LOGIC_NOTA = 2'b11;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StExec = 2'd1,
    StHold = 2'd2
  } issue_state_e;

  typedef struct packed {
    logic [7:0] a;
    logic [7:0] b;
    logic [1:0] sel;
  } cmd_op_t;

endpackage

// File: rtl/cmd_fifo2.sv
// Two-entry synchronous FIFO, no bypass.
//   clk_i, rst_i       clock, synchronous active-high reset (empties the FIFO)
//   push_i, wdata_i    write request and data; ignored when full
//   pop_i, rdata_o     read request and head-of-queue data; ignored when empty
//   full_o, empty_o    occupancy flags
module cmd_fifo2 #(
  parameter int unsigned Width = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic [Width-1:0] wdata_i,
  input  logic             pop_i,
  output logic [Width-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o
);

  logic [Width-1:0] mem_q [2];
  logic             wr_ptr_q, rd_ptr_q;
  logic [1:0]       count_q;
  logic             do_push, do_pop;

  assign full_o  = (count_q == 2'd2);
  assign empty_o = (count_q == 2'd0);
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;
  assign rdata_o = mem_q[rd_ptr_q];

  // Storage needs no reset; occupancy tracking makes stale entries unreachable.
  always_ff @(posedge clk_i) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= wdata_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      if (do_push) wr_ptr_q <= ~wr_ptr_q;
      if (do_pop)  rd_ptr_q <= ~rd_ptr_q;
      unique case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 2'd1;
        2'b01:   count_q <= count_q - 2'd1;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/logic_unit.sv
// Combinational 8-bit logic unit.
//   A, B       operands
//   Logic_Sel  operation select (AND / OR / XOR / NOT A)
//   Logic_Out  result
module logic_unit
  import alu_pkg::*;
(
  input  logic [7:0] A,
  input  logic [7:0] B,
  input  logic [1:0] Logic_Sel,
  output logic [7:0] Logic_Out
);

  always_comb begin
    Logic_Out = 8'h00;
    unique case (Logic_Sel)
      LOGIC_AND:  Logic_Out = A & B;
      LOGIC_OR:   Logic_Out = A | B;
      LOGIC_XOR:  Logic_Out = A ^ B;
      LOGIC_NOTA: Logic_Out = ~A;
      default:    Logic_Out = 8'h00;
    endcase
  end

endmodule

// File: rtl/logic_issue_ctrl.sv
// Streaming front end for logic_unit.
//   clk, rst                       clock, synchronous active-high reset
//   cmd_valid/cmd_ready            command handshake; cmd_A, cmd_B, cmd_Sel payload
//   res_valid/res_ready            result handshake
//   res_data, res_zero, res_tag    held result, its zero flag and its command tag
// Commands are tagged on accept, queued in a 2-entry FIFO, issued one at a
// time through registered operands and the result is held until consumed.
module logic_issue_ctrl
  import alu_pkg::*;
#(
  parameter int unsigned TAG_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [7:0]       cmd_A,
  input  logic [7:0]       cmd_B,
  input  logic [1:0]       cmd_Sel,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [7:0]       res_data,
  output logic             res_zero,
  output logic [TAG_W-1:0] res_tag
);

  typedef struct packed {
    logic [TAG_W-1:0] tag;
    cmd_op_t          op;
  } cmd_t;

  localparam int unsigned CmdW = $bits(cmd_t);

  issue_state_e     state_q, state_d;
  logic [TAG_W-1:0] tag_q;
  logic [7:0]       op_a_q, op_b_q;
  logic [1:0]       op_sel_q;
  logic [TAG_W-1:0] op_tag_q;
  logic             res_valid_q;
  logic [7:0]       res_data_q;
  logic             res_zero_q;
  logic [TAG_W-1:0] res_tag_q;

  logic             fifo_full, fifo_empty;
  logic             push, pop, capture, consume;
  cmd_t             push_cmd, head_cmd;
  logic [7:0]       logic_out;

  // Ready is withheld while a pop is in flight on a full FIFO, so there is no
  // same-cycle pop-to-push pass-through.
  assign cmd_ready = !rst && !fifo_full;
  assign push      = cmd_valid && cmd_ready;

  always_comb begin
    push_cmd        = '0;
    push_cmd.tag    = tag_q;
    push_cmd.op.a   = cmd_A;
    push_cmd.op.b   = cmd_B;
    push_cmd.op.sel = cmd_Sel;
  end

  cmd_fifo2 #(
    .Width(CmdW)
  ) u_fifo (
    .clk_i  (clk),
    .rst_i  (rst),
    .push_i (push),
    .wdata_i(push_cmd),
    .pop_i  (pop),
    .rdata_o(head_cmd),
    .full_o (fifo_full),
    .empty_o(fifo_empty)
  );

  logic_unit u_logic_unit (
    .A        (op_a_q),
    .B        (op_b_q),
    .Logic_Sel(op_sel_q),
    .Logic_Out(logic_out)
  );

  always_comb begin
    state_d = state_q;
    pop     = 1'b0;
    capture = 1'b0;
    consume = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (!fifo_empty) begin
          pop     = 1'b1;
          state_d = StExec;
        end
      end
      StExec: begin
        capture = 1'b1;
        state_d = StHold;
      end
      StHold: begin
        if (res_ready) begin
          consume = 1'b1;
          if (!fifo_empty) begin
            pop     = 1'b1;
            state_d = StExec;
          end else begin
            state_d = StIdle;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      tag_q       <= '0;
      op_a_q      <= 8'h00;
      op_b_q      <= 8'h00;
      op_sel_q    <= 2'b00;
      op_tag_q    <= '0;
      res_valid_q <= 1'b0;
      res_data_q  <= 8'h00;
      res_zero_q  <= 1'b0;
      res_tag_q   <= '0;
    end else begin
      state_q <= state_d;
      if (push) tag_q <= tag_q + TAG_W'(1);
      if (pop) begin
        op_a_q   <= head_cmd.op.a;
        op_b_q   <= head_cmd.op.b;
        op_sel_q <= head_cmd.op.sel;
        op_tag_q <= head_cmd.tag;
      end
      if (capture) begin
        res_data_q  <= logic_out;
        res_zero_q  <= (logic_out == 8'h00);
        res_tag_q   <= op_tag_q;
        res_valid_q <= 1'b1;
      end else if (consume) begin
        res_valid_q <= 1'b0;
      end
    end
  end

  assign res_valid = res_valid_q;
  assign res_data  = res_data_q;
  assign res_zero  = res_zero_q;
  assign res_tag   = res_tag_q;

endmodule

// File: tb/tb_logic_issue_ctrl.sv
module tb_logic_issue_ctrl;

  typedef struct packed {
    logic [3:0] tag;
    logic [7:0] data;
    logic       zero;
  } res_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [7:0] cmd_A, cmd_B;
  logic [1:0] cmd_Sel;
  logic       res_valid;
  logic       res_ready;
  logic [7:0] res_data;
  logic       res_zero;
  logic [3:0] res_tag;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  res_t       exp_q[$];
  res_t       got_q[$];
  logic [3:0] model_tag;

  logic_issue_ctrl #(
    .TAG_W(4)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .cmd_A    (cmd_A),
    .cmd_B    (cmd_B),
    .cmd_Sel  (cmd_Sel),
    .res_valid(res_valid),
    .res_ready(res_ready),
    .res_data (res_data),
    .res_zero (res_zero),
    .res_tag  (res_tag)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] model_op(logic [7:0] a, logic [7:0] b, logic [1:0] sel);
    case (sel)
      2'd0:    return a & b;
      2'd1:    return a | b;
      2'd2:    return a ^ b;
      default: return ~a;
    endcase
  endfunction

  task automatic check_eq(string name, logic [31:0] got, logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // Observe handshakes half a cycle ahead of the edge that completes them.
  always @(negedge clk) begin
    if (rst) begin
      model_tag <= 4'd0;
      exp_q.delete();
    end else begin
      if (cmd_valid && cmd_ready) begin
        res_t e;
        e.tag  = model_tag;
        e.data = model_op(cmd_A, cmd_B, cmd_Sel);
        e.zero = (e.data == 8'h00);
        exp_q.push_back(e);
        model_tag <= model_tag + 4'd1;
      end
      if (res_valid && res_ready) got_q.push_back({res_tag, res_data, res_zero});
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present a command and return just after the edge that accepts it.
  task automatic send(logic [7:0] a, logic [7:0] b, logic [1:0] sel);
    bit done = 0;
    cmd_A     = a;
    cmd_B     = b;
    cmd_Sel   = sel;
    cmd_valid = 1'b1;
    for (int i = 0; i < 100 && !done; i++) begin
      @(negedge clk);
      if (cmd_ready) begin
        @(posedge clk);
        #1;
        done = 1;
      end
    end
    if (!done) check_eq("send_timeout", 0, 1);
  endtask

  task automatic wait_results(int n);
    for (int i = 0; i < 500 && got_q.size() < n; i++) @(negedge clk);
    check_eq("result_count", got_q.size(), n);
  endtask

  task automatic clear_queues();
    exp_q.delete();
    got_q.delete();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] exp_d1 [4] = '{8'h02, 8'h0A, 8'h08, 8'hF5};
    logic [7:0] exp_d3 [3] = '{8'h0C, 8'h3F, 8'h33};
    bit seen;

    rst = 1'b1; cmd_valid = 1'b0; cmd_A = '0; cmd_B = '0; cmd_Sel = '0; res_ready = 1'b0;
    repeat (3) tick();
    @(negedge clk);
    check_eq("ready_in_reset", cmd_ready, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check_eq("ready_after_reset", cmd_ready, 1);
    check_eq("valid_after_reset", res_valid, 0);
    check_eq("data_after_reset", res_data, 8'h00);
    check_eq("zero_after_reset", res_zero, 0);
    check_eq("tag_after_reset", res_tag, 0);
    tick();

    // Four ops on A=0A, B=02, consumer always ready.
    clear_queues();
    res_ready = 1'b1;
    for (int s = 0; s < 4; s++) send(8'h0A, 8'h02, 2'(s));
    cmd_valid = 1'b0;
    wait_results(4);
    for (int i = 0; i < 4 && i < got_q.size(); i++) begin
      check_eq($sformatf("seq_data%0d", i), got_q[i].data, exp_d1[i]);
      check_eq($sformatf("seq_tag%0d", i), got_q[i].tag, i);
      check_eq($sformatf("seq_zero%0d", i), got_q[i].zero, 0);
    end
    repeat (3) tick();

    // Zero result and two-cycle latency from accept.
    clear_queues();
    send(8'hF6, 8'h09, 2'd0);
    cmd_valid = 1'b0;
    @(negedge clk);
    check_eq("lat_valid_n0", res_valid, 0);
    @(negedge clk);
    check_eq("lat_valid_n1", res_valid, 0);
    @(negedge clk);
    check_eq("lat_valid_n2", res_valid, 1);
    check_eq("zero_data", res_data, 8'h00);
    check_eq("zero_flag", res_zero, 1);
    check_eq("zero_tag", res_tag, 4);
    repeat (3) tick();

    // Stall: three commands with consumer blocked.
    clear_queues();
    res_ready = 1'b0;
    send(8'h3C, 8'h0F, 2'd0);
    send(8'h3C, 8'h0F, 2'd1);
    send(8'h3C, 8'h0F, 2'd2);
    cmd_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_eq($sformatf("stall_ready%0d", i), cmd_ready, 0);
      check_eq($sformatf("stall_valid%0d", i), res_valid, 1);
      check_eq($sformatf("stall_data%0d", i), res_data, 8'h0C);
      check_eq($sformatf("stall_tag%0d", i), res_tag, 5);
    end
    @(posedge clk); #1;
    res_ready = 1'b1;
    @(negedge clk);
    check_eq("release_ready_before_pop", cmd_ready, 0);
    @(negedge clk);
    check_eq("release_ready_after_pop", cmd_ready, 1);
    wait_results(3);
    for (int i = 0; i < 3 && i < got_q.size(); i++) begin
      check_eq($sformatf("drain_data%0d", i), got_q[i].data, exp_d3[i]);
      check_eq($sformatf("drain_tag%0d", i), got_q[i].tag, 5 + i);
    end
    repeat (3) tick();

    // Reset while a result is held.
    clear_queues();
    res_ready = 1'b0;
    send(8'h55, 8'hAA, 2'd1);
    cmd_valid = 1'b0;
    seen = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      seen = res_valid;
    end
    check_eq("hold_reached", seen, 1);
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    check_eq("rst_hold_ready", cmd_ready, 0);
    check_eq("rst_hold_valid_pre", res_valid, 1);
    @(negedge clk);
    check_eq("rst_hold_valid", res_valid, 0);
    check_eq("rst_hold_data", res_data, 8'h00);
    check_eq("rst_hold_tag", res_tag, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    res_ready = 1'b1;
    tick();

    // Tag wrap over 17 commands after the reset.
    clear_queues();
    for (int i = 0; i < 17; i++) send(8'(i * 7 + 1), 8'hF0 ^ 8'(i), 2'(i % 4));
    cmd_valid = 1'b0;
    wait_results(17);
    for (int i = 0; i < 17 && i < got_q.size(); i++) begin
      check_eq($sformatf("wrap_tag%0d", i), got_q[i].tag, i % 16);
      check_eq($sformatf("wrap_data%0d", i), got_q[i].data,
               model_op(8'(i * 7 + 1), 8'hF0 ^ 8'(i), 2'(i % 4)));
    end
    repeat (3) tick();

    // Random handshake toggling against the scoreboard.
    clear_queues();
    for (int c = 0; c < 400; c++) begin
      cmd_valid = 1'($urandom_range(0, 1));
      cmd_A     = 8'($urandom);
      cmd_B     = 8'($urandom);
      cmd_Sel   = 2'($urandom);
      res_ready = 1'($urandom_range(0, 1));
      tick();
    end
    cmd_valid = 1'b0;
    res_ready = 1'b1;
    for (int i = 0; i < 100 && got_q.size() < exp_q.size(); i++) @(negedge clk);
    repeat (4) tick();
    check_eq("rand_count", got_q.size(), exp_q.size());
    check_eq("rand_nonempty", exp_q.size() > 20, 1);
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      check_eq($sformatf("rand_entry%0d", i), got_q[i], exp_q[i]);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
